// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice per clock, LSB first.
// A result takes WIDTH SHIFT cycles followed by a single DONE cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // The visible result is published on the same edge that processes the
    // final bit, so it is already valid during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        carry   <= cin_in;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sum_sr  <= {s_bit, sum_sr[WIDTH-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= {s_bit, sum_sr[WIDTH-1:1]};
                        cout <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8, covering
// latency, result hold, ignored start, mid-operation reset and back-to-back ops.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin_in (cin_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // One full addition with fixed-latency checks; previous result must hold through SHIFT.
    task automatic do_add(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                          input logic [WIDTH-1:0] prev_sum, input logic prev_cout);
        apply_stimulus(a, b, c);
        for (int i = 0; i < WIDTH; i++) begin
            check_output({tag, " busy"}, 32'(busy), 32'd1);
            check_output({tag, " done_low"}, 32'(done), 32'd0);
            check_output({tag, " sum_hold"}, 32'(sum), 32'(prev_sum));
            check_output({tag, " cout_hold"}, 32'(cout), 32'(prev_cout));
            tick();
        end
        check_output({tag, " done"}, 32'(done), 32'd1);
        check_output({tag, " busy_low"}, 32'(busy), 32'd0);
        check_output({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check_output({tag, " cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check_output({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        logic [WIDTH-1:0] exp_s [3];
        logic             exp_c [3];
        logic [WIDTH-1:0] nxt_a [3];
        logic [WIDTH-1:0] nxt_b [3];

        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        tick();
        tick();
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        check_output("reset sum", 32'(sum), 32'd0);
        check_output("reset cout", 32'(cout), 32'd0);

        // Reset beats a simultaneous start.
        a_in  = 8'h11;
        b_in  = 8'h11;
        start = 1'b1;
        tick();
        check_output("rst_prio busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        do_add("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b0);
        do_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h4B, 1'b0);
        do_add("add_5a_a5_c", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
        do_add("add_3c_0f_b", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b1);
        do_add("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h4B, 1'b0);
        do_add("add_c3_96_c", 8'hC3, 8'h96, 1'b1, 8'h5A, 1'b1, 8'h00, 1'b0);

        // Start and new operands during SHIFT cycle 3 are ignored.
        apply_stimulus(8'h12, 8'h34, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 2) begin
                start  = 1'b1;
                a_in   = 8'hFF;
                b_in   = 8'hFF;
                cin_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) done_cnt++;
            tick();
        end
        start = 1'b0;
        check_output("ignore done", 32'(done), 32'd1);
        check_output("ignore sum", 32'(sum), 32'h46);
        check_output("ignore cout", 32'(cout), 32'd0);
        for (int i = 0; i < 14; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check_output("ignore one_pulse", 32'(done_cnt), 32'd1);

        // Reset in SHIFT cycle 4 discards the operation.
        apply_stimulus(8'h11, 8'h22, 1'b0);
        tick();
        tick();
        tick();
        check_output("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst done", 32'(done), 32'd0);
        check_output("midrst sum", 32'(sum), 32'd0);
        check_output("midrst cout", 32'(cout), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check_output("midrst no_done", 32'(done_cnt), 32'd0);
        do_add("after_rst", 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 8'h00, 1'b0);

        // Start held high across three back-to-back operations.
        exp_s = '{8'h02, 8'h00, 8'h80};
        exp_c = '{1'b0, 1'b1, 1'b0};
        nxt_a = '{8'h80, 8'h7F, 8'h00};
        nxt_b = '{8'h80, 8'h01, 8'h00};
        a_in   = 8'h01;
        b_in   = 8'h01;
        cin_in = 1'b0;
        start  = 1'b1;
        done_cnt  = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 40 && done_cnt < 3; cyc++) begin
            tick();
            if (done) begin
                check_output("b2b sum", 32'(sum), 32'(exp_s[done_cnt]));
                check_output("b2b cout", 32'(cout), 32'(exp_c[done_cnt]));
                if (last_done >= 0)
                    check_output("b2b spacing", 32'(cyc - last_done), 32'd10);
                else
                    check_output("b2b first_latency", 32'(cyc), 32'd8);
                last_done = cyc;
                a_in = nxt_a[done_cnt];
                b_in = nxt_b[done_cnt];
                done_cnt++;
            end
        end
        start = 1'b0;
        check_output("b2b count", 32'(done_cnt), 32'd3);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
